// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
//   Bundles the requester side and the display pins of seg_display_arbiter.
//   master: vending-side driver (requests, data, enable); observes grant/display.
//   slave : the arbiter itself.
// Signals
//   seg_en       display enable
//   req[NREQ]    level request per requester, index 0 = highest priority
//   data         NREQ x 32-bit: nibble k of requester i = data[i*32+4k +: 4]
//   grant        one-hot current owner (0 when none)
//   grant_pulse  1-cycle pulse on a new non-zero grant
//   frame_done   1-cycle pulse at the start of every frame
//   dig_out      one-hot digit enable, active-high
//   seg_out      {dp,g,f,e,d,c,b,a}, active-high
interface seg_display_arbiter_if #(parameter int NREQ = 4);
  logic                 seg_en;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   data;
  logic [NREQ-1:0]      grant;
  logic                 grant_pulse;
  logic                 frame_done;
  logic [7:0]           dig_out;
  logic [7:0]           seg_out;

  modport master (
    output seg_en, req, data,
    input  grant, grant_pulse, frame_done, dig_out, seg_out
  );

  modport slave (
    input  seg_en, req, data,
    output grant, grant_pulse, frame_done, dig_out, seg_out
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares an 8-digit seven-segment display between NREQ requesters. One owner
//   is chosen by fixed priority (index 0 highest) with a minimum hold of
//   HOLD_FRAMES frames; the owner's 8 nibbles are latched once per frame and
//   scanned out one digit per SCAN_DIV clocks. Owner changes always pass
//   through one fully blank frame.
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   bus          seg_display_arbiter_if.slave (req/data/seg_en in,
//                grant/grant_pulse/frame_done/dig_out/seg_out out)
// Configuration
//   SEG_LEAD_BLANK_EN  when defined, leading-zero digits (7 down to 1) drive
//                      seg_out=0 while dig_out keeps scanning.
module seg_display_arbiter #(
  parameter int NREQ        = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_display_arbiter_if.slave bus
);

  localparam int DIVW  = (SCAN_DIV    > 1) ? $clog2(SCAN_DIV)    : 1;
  localparam int OWNW  = (NREQ        > 1) ? $clog2(NREQ)        : 1;
  localparam int HOLDW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [DIVW-1:0]  DIV_LAST  = DIVW'(SCAN_DIV - 1);
  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_SWITCH} state_t;

  state_t            r_state;
  logic [DIVW-1:0]   r_div;
  logic [2:0]        r_idx;
  logic [HOLDW-1:0]  r_hold;
  logic [OWNW-1:0]   r_owner;
  logic [31:0]       r_buf;
  logic [NREQ-1:0]   r_grant;
  logic              r_gpulse;
  logic              r_fdone;
  logic [7:0]        r_dig;
  logic [7:0]        r_seg;

  state_t            w_state_nxt;
  logic [HOLDW-1:0]  w_hold_nxt;
  logic [OWNW-1:0]   w_owner_nxt;
  logic [OWNW-1:0]   w_low;
  logic              w_any;
  logic              w_higher;
  logic              w_wrap;
  logic              w_b;
  logic [DIVW-1:0]   w_div_nxt;
  logic [2:0]        w_idx_nxt;
  logic [31:0]       w_slice;
  logic [31:0]       w_buf_nxt;
  logic [NREQ-1:0]   w_grant_nxt;
  logic [3:0]        w_nib;
  logic [7:0]        w_lead;
  logic              w_blank;
  logic              w_show;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 8'h3F;  4'h1: seg_decode = 8'h06;
      4'h2: seg_decode = 8'h5B;  4'h3: seg_decode = 8'h4F;
      4'h4: seg_decode = 8'h66;  4'h5: seg_decode = 8'h6D;
      4'h6: seg_decode = 8'h7D;  4'h7: seg_decode = 8'h07;
      4'h8: seg_decode = 8'h7F;  4'h9: seg_decode = 8'h6F;
      4'hA: seg_decode = 8'h77;  4'hB: seg_decode = 8'h7C;
      4'hC: seg_decode = 8'h39;  4'hD: seg_decode = 8'h5E;
      4'hE: seg_decode = 8'h79;  default: seg_decode = 8'h71;
    endcase
  endfunction

  // Scan timing; B is the last cycle of a frame
  assign w_wrap    = (r_div == DIV_LAST);
  assign w_b       = w_wrap && (r_idx == 3'd7);
  assign w_div_nxt = w_wrap ? '0 : r_div + 1'b1;
  assign w_idx_nxt = w_wrap ? r_idx + 3'd1 : r_idx;   // 7 wraps to 0
  assign w_any     = |bus.req;

  // Lowest set index wins; also flag any pending request above the owner
  always_comb begin
    w_low    = '0;
    w_higher = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[i]) w_low = OWNW'(i);
    for (int i = 0; i < NREQ; i++)
      if (bus.req[i] && (OWNW'(i) < r_owner)) w_higher = 1'b1;
  end

  // Next-state logic; only the B cycle can move the FSM
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    if (w_b) begin
      case (r_state)
        S_IDLE, S_SWITCH: begin
          if (w_any) begin
            w_state_nxt = S_OWN;
            w_owner_nxt = w_low;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_OWN: begin
          if (!bus.req[r_owner])
            w_state_nxt = w_any ? S_SWITCH : S_IDLE;
          else if (w_higher && (r_hold >= HOLD_LAST))
            w_state_nxt = S_SWITCH;
          else if (r_hold < HOLD_LAST)
            w_hold_nxt = r_hold + 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Owner's data slice, one-hot grant for the next cycle
  always_comb begin
    w_slice     = '0;
    w_grant_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_owner_nxt == OWNW'(i)) w_slice = bus.data[i*32 +: 32];
      w_grant_nxt[i] = (w_state_nxt == S_OWN) && (w_owner_nxt == OWNW'(i));
    end
  end

  // Buffer only reloads at B, so mid-frame data changes are invisible
  assign w_buf_nxt = !w_b                  ? r_buf   :
                     (w_state_nxt == S_OWN) ? w_slice : 32'h0;

  assign w_nib = w_buf_nxt[{w_idx_nxt, 2'b00} +: 4];

`ifdef SEG_LEAD_BLANK_EN
  // w_lead[k]: digits 7..k are all zero; digit 0 is always shown
  always_comb begin
    w_lead    = '0;
    w_lead[7] = (w_buf_nxt[31:28] == 4'h0);
    for (int k = 6; k >= 1; k--)
      w_lead[k] = w_lead[k+1] && (w_buf_nxt[k*4 +: 4] == 4'h0);
  end
  assign w_blank = w_lead[w_idx_nxt];
`else
  assign w_lead  = '0;
  assign w_blank = 1'b0;
`endif

  // Display blank outside OWN; seg_en gates the pins only
  assign w_show = bus.seg_en && (w_state_nxt == S_OWN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_idx    <= '0;
      r_hold   <= '0;
      r_owner  <= '0;
      r_buf    <= '0;
      r_grant  <= '0;
      r_gpulse <= 1'b0;
      r_fdone  <= 1'b0;
      r_dig    <= '0;
      r_seg    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_idx    <= w_idx_nxt;
      r_hold   <= w_hold_nxt;
      r_owner  <= w_owner_nxt;
      r_buf    <= w_buf_nxt;
      r_grant  <= w_grant_nxt;
      // a new owner can only appear on entry to OWN
      r_gpulse <= w_b && (w_state_nxt == S_OWN) && (r_state != S_OWN);
      r_fdone  <= w_b;
      r_dig    <= w_show ? (8'h01 << w_idx_nxt) : 8'h00;
      r_seg    <= (w_show && !w_blank) ? seg_decode(w_nib) : 8'h00;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_pulse = r_gpulse;
  assign bus.frame_done  = r_fdone;
  assign bus.dig_out     = r_dig;
  assign bus.seg_out     = r_seg;

endmodule
